// File: rtl/shift_enable_gen_if.sv
// shift_enable_gen_if: request/status bundle for the shift-enable sequencer.
// master drives start/len/hold; slave returns shift_ena/busy/done/remaining.
interface shift_enable_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             hold;
  logic             shift_ena;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, len, hold,
    input  shift_ena, busy, done, remaining
  );

  modport slave (
    input  start, len, hold,
    output shift_ena, busy, done, remaining
  );
endinterface

// File: rtl/shift_enable_gen.sv
// shift_enable_gen: issues shift_ena for len cycles after start, then done.
// Ports: clk, reset (async, active-low), bus (slave). Option: SHIFT_ENA_RETRIGGER_EN.
module shift_enable_gen #(
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  shift_enable_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } st_t;

  st_t              st;
  st_t              st_n;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_n;
  logic             ena_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    st_n  = st;
    rem_n = rem;
    unique case (st)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            st_n  = RUN;
            rem_n = bus.len;
          end else begin
            st_n  = DONE;
            rem_n = '0;
          end
        end else begin
          st_n = IDLE;
        end
      end
      RUN: begin
        rem_n = rem - CNT_W'(1);
        // terminal count wins over hold
        if (rem == CNT_W'(1))
          st_n = DONE;
        else if (bus.hold)
          st_n = HOLD;
        else
          st_n = RUN;
      end
      HOLD: begin
        if (!bus.hold)
          st_n = RUN;
      end
    endcase
`ifdef SHIFT_ENA_RETRIGGER_EN
    // retrigger reloads and overrides count/hold
    if (bus.start && (st == RUN || st == HOLD)) begin
      if (bus.len != '0) begin
        st_n  = RUN;
        rem_n = bus.len;
      end else begin
        st_n  = DONE;
        rem_n = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      rem    <= '0;
      ena_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      rem    <= rem_n;
      ena_q  <= (st_n == RUN);
      busy_q <= (st_n == RUN) || (st_n == HOLD);
      done_q <= (st_n == DONE);
    end
  end

  assign bus.shift_ena = ena_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem;

endmodule

// File: doc/shift_enable_gen.md
# shift_enable_gen

Programmable shift-enable sequencer: on a `start` request it asserts `shift_ena` for exactly `len` enabled clock cycles, then pulses `done`. It generalises the fixed four-cycle shift enabler with a run-time length, a pause input, status outputs and optional retrigger. It sits between the pattern detector (which raises `start`) and the shift register that loads the timer delay.

## Interface
- `CNT_W`, 4: width of the length input and down-counter; max run length 2^CNT_W-1 cycles.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; forces IDLE immediately.
- `start` in 1: synchronous request; sampled each rising edge.
- `len` in CNT_W: number of `shift_ena` cycles; sampled only on an accepted `start`.
- `hold` in 1: pause request; sampled each rising edge.
- `shift_ena` out 1: high while state is RUN.
- `busy` out 1: high in RUN or HOLD.
- `done` out 1: one-cycle pulse, high while state is DONE.
- `remaining` out CNT_W: enable cycles still to be issued.

## Operation
- States: IDLE, RUN, HOLD, DONE. All outputs decode from registered state and counter `rem`; no combinational input-to-output paths.
- `shift_ena` = (state==RUN); `busy` = RUN|HOLD; `done` = (state==DONE); `remaining` = `rem`.
- IDLE or DONE, `start`=1: `len`≠0 → RUN, `rem`←`len`; `len`=0 → DONE, `rem`←0. `start` accepted in DONE (back-to-back runs, no IDLE gap).
- IDLE/DONE, `start`=0: → IDLE, `rem` unchanged (0).
- RUN, each edge: `rem`←`rem`-1. If `rem`==1 → DONE. Else if `hold` → HOLD. Else stay RUN.
- HOLD: `rem` frozen; `hold`=0 → RUN, else stay HOLD.
- Terminal count has priority over `hold`: a run always ends in DONE after exactly `len` RUN cycles, independent of hold activity.
- `start` during RUN/HOLD: see Configuration.
- `rem` never wraps: decrement occurs only in RUN where `rem`≥1.

## Timing
- Reset (asserted, async): state=IDLE, `rem`=0, `shift_ena`=0, `busy`=0, `done`=0, `remaining`=0. Release is synchronised externally; first `start` honoured at the first edge after release.
- `start` with `len`=L≥1 sampled at edge k: `shift_ena` high in cycles k..k+L-1 (counting cycle following edge k as k), `done` high in cycle k+L, `busy` low in cycle k+L.
- `len`=0: `done` high in cycle after the `start` edge; `shift_ena` never asserts.
- `hold` sampled high at edge in RUN: `shift_ena` drops in the next cycle; `hold` sampled low in HOLD: `shift_ena` returns the next cycle. Each hold episode adds ≥1 cycle gap; total enable cycles remain L.
- `hold` outside RUN/HOLD: ignored.

## Configuration
- `SHIFT_ENA_RETRIGGER_EN` defined: `start` in RUN or HOLD reloads `rem`←`len` and goes to RUN (`len`=0 → DONE); `start` overrides terminal count and `hold` on the same edge. Enables counted from the retrigger edge.
- Not defined: `start` in RUN/HOLD ignored; `len` not sampled; run completes unaffected.

## Test plan
- Reset then `start`=1, `len`=4 for one cycle → `shift_ena` high exactly 4 cycles, `remaining` 4,3,2,1, `done` one pulse next cycle, then IDLE with all outputs 0.
- `start`, `len`=6, `hold` high for 3 cycles after 2nd enable cycle → `shift_ena` pattern 1,1,0,0,0,1,1,1,1 (6 total), `done` once after last.
- `len`=0 → `done` pulse next cycle, `shift_ena` and `busy` stay 0; then `start` in DONE cycle with `len`=2 → 2 enable cycles with no IDLE gap.
- `start` `len`=5, reassert `start` `len`=3 after 2 enable cycles → with macro: 2+3=5 enables total; without: 5 enables, second `start` ignored.
- `reset` asserted mid-RUN (`remaining`=3), asynchronous to `clk` → all outputs 0 immediately, no `done` pulse; next `start` `len`=15 gives 15 enables.
- `hold` held high throughout final RUN cycle (`rem`=1) → DONE reached, `done` pulses, no HOLD entry.
